// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants: word sizes, state encodings, reset PC, byte-lane helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_stage_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;

  localparam logic [INST_LEN-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [ADDR_LEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Two states: FETCH gathers four bytes, HOLD presents the word downstream.
  localparam int IF_STATE_LEN = 1;
  localparam logic [IF_STATE_LEN-1:0] IF_FETCH = 1'b0;
  localparam logic [IF_STATE_LEN-1:0] IF_HOLD  = 1'b1;

  // Replace byte lane idx of a little-endian word.
  function automatic logic [INST_LEN-1:0] set_byte(input logic [INST_LEN-1:0] w,
                                                   input logic [1:0] idx,
                                                   input logic [7:0] b);
    logic [INST_LEN-1:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: byte memory request/ack side plus IF/ID presentation side.
// Latency: n/a (wires only).
// Backpressure: stall_i holds the presented word; mem_ack_i paces byte fetches.
interface if_stage_if #(
  parameter int ADDR_W = 32
);
  import if_stage_pkg::*;

  logic                stall_i;
  logic                jump_i;
  logic [ADDR_W-1:0]   jump_addr_i;
  logic                mem_req_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic                mem_ack_i;
  logic [7:0]          mem_data_i;
  logic                inst_valid_o;
  logic [ADDR_W-1:0]   pc_o;
  logic [INST_LEN-1:0] inst_o;

  // Fetch stage side.
  modport master (
    input  stall_i, jump_i, jump_addr_i, mem_ack_i, mem_data_i,
    output mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o
  );

  // Environment side (memory controller, decode, execute).
  modport slave (
    output stall_i, jump_i, jump_addr_i, mem_ack_i, mem_data_i,
    input  mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o
  );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch: assembles 32-bit words from four byte fetches and presents {pc, inst}.
// Latency: >=4 cycles request-to-valid, one word per 5 cycles unstalled.
// Backpressure: stall_i holds the word in HOLD; no ack holds the request; rdy=0 freezes all.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  if_stage_if.master bus
);

  logic [IF_STATE_LEN-1:0] state_q, state_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [INST_LEN-1:0]     buf_q, buf_d;
  logic                    valid_q, valid_d;
  logic [ADDR_W-1:0]       pc_out_q, pc_out_d;
  logic [INST_LEN-1:0]     inst_q, inst_d;

  // Memory request is only live while fetching and the pipeline is running.
  always_comb begin
    bus.mem_req_o  = rdy & ~rst & (state_q == IF_FETCH);
    bus.mem_addr_o = pc_q + {{(ADDR_W-2){1'b0}}, byte_idx_q};
    bus.inst_valid_o = valid_q;
    bus.pc_o       = pc_out_q;
    bus.inst_o     = inst_q;
  end

  // Next-state: redirect wins, then byte collection in FETCH, then consumption in HOLD.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    valid_d    = valid_q;
    pc_out_d   = pc_out_q;
    inst_d     = inst_q;
    if (rdy) begin
      if (bus.jump_i) begin
        // Any ack landing this cycle belongs to the abandoned path and is dropped.
        pc_d       = bus.jump_addr_i;
        byte_idx_d = 2'd0;
        buf_d      = ZERO_WORD;
        valid_d    = 1'b0;
        state_d    = IF_FETCH;
      end else if (state_q == IF_FETCH) begin
        if (bus.mem_ack_i) begin
          buf_d = set_byte(buf_q, byte_idx_q, bus.mem_data_i);
          if (byte_idx_q == 2'd3) begin
            inst_d     = {bus.mem_data_i, buf_q[23:0]};
            pc_out_d   = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_W'(4);
            byte_idx_d = 2'd0;
            state_d    = IF_HOLD;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end else begin
        if (!bus.stall_i) begin
          valid_d = 1'b0;
          state_d = IF_FETCH;
        end
      end
    end
  end

  // State registers with synchronous reset; rdy=0 leaves d equal to q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_FETCH;
      byte_idx_q <= 2'd0;
      pc_q       <= RESET_PC;
      buf_q      <= ZERO_WORD;
      valid_q    <= 1'b0;
      pc_out_q   <= '0;
      inst_q     <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      inst_q     <= inst_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: transaction-level model plus directed and random stimulus.
// Latency: checks every cycle, combinational outputs before the edge, registered ones after.
// Backpressure: randomizes stall_i, rdy, jump_i and ack gaps.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  if_stage_if #(.ADDR_W(32)) bus_if ();

  if_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: where the fetch is, which bytes have arrived, what is presented.
  logic [31:0] m_pc;
  logic [7:0]  m_bytes[$];
  logic        m_valid;
  logic [31:0] m_out_pc;
  logic [31:0] m_inst;

  logic        seen_req;
  logic [31:0] seen_addr;

  // Memory image: first word is 0x00000013, everything else a per-address pattern.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a == 32'd0) return 8'h13;
    if (a < 32'd4)  return 8'h00;
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_bytes.delete(); m_valid = 1'b0; m_out_pc = 32'h0; m_inst = 32'h0;
    end else if (rdy) begin
      if (bus_if.jump_i) begin
        m_pc = bus_if.jump_addr_i; m_bytes.delete(); m_valid = 1'b0;
      end else if (m_valid) begin
        if (!bus_if.stall_i) m_valid = 1'b0;
      end else if (bus_if.mem_ack_i) begin
        m_bytes.push_back(bus_if.mem_data_i);
        if (m_bytes.size() == 4) begin
          m_inst   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_out_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_bytes.delete();
          m_valid  = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs, check the request, act as memory, then check registered outputs.
  task automatic step(input logic r, input logic rd, input logic st, input logic j,
                      input logic [31:0] ja, input int ack_pct);
    logic        exp_req;
    logic [31:0] exp_addr;
    @(negedge clk);
    rst = r; rdy = rd;
    bus_if.stall_i = st; bus_if.jump_i = j; bus_if.jump_addr_i = ja;
    #1;
    exp_req  = !r && rd && !m_valid;
    exp_addr = m_pc + 32'(m_bytes.size());
    seen_req  = bus_if.mem_req_o;
    seen_addr = bus_if.mem_addr_o;
    chk("mem_req", {31'd0, seen_req}, {31'd0, exp_req});
    if (exp_req) chk("mem_addr", seen_addr, exp_addr);
    bus_if.mem_ack_i  = exp_req && (int'($urandom_range(99)) < ack_pct);
    bus_if.mem_data_i = bus_if.mem_ack_i ? mem_byte(exp_addr) : 8'($urandom);
    @(posedge clk);
    model_step();
    #1;
    chk("inst_valid", {31'd0, bus_if.inst_valid_o}, {31'd0, m_valid});
    if (m_valid) begin
      chk("pc_o", bus_if.pc_o, m_out_pc);
      chk("inst_o", bus_if.inst_o, m_inst);
      chk("inst_vs_mem", bus_if.inst_o,
          {mem_byte(m_out_pc + 32'd3), mem_byte(m_out_pc + 32'd2),
           mem_byte(m_out_pc + 32'd1), mem_byte(m_out_pc)});
    end
  endtask

  initial begin
    bus_if.stall_i = 1'b0; bus_if.jump_i = 1'b0; bus_if.jump_addr_i = 32'h0;
    bus_if.mem_ack_i = 1'b0; bus_if.mem_data_i = 8'h00;
    m_pc = 32'h0; m_valid = 1'b0; m_out_pc = 32'h0; m_inst = 32'h0;
    seen_req = 1'b0; seen_addr = 32'h0;

    // Reset.
    step(1, 1, 0, 0, 32'h0, 100);
    step(1, 1, 0, 0, 32'h0, 100);
    chk("rst_valid", {31'd0, bus_if.inst_valid_o}, 32'd0);
    chk("rst_pc", bus_if.pc_o, 32'h0);
    chk("rst_inst", bus_if.inst_o, 32'h0);

    // First word from 0x0..0x3.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 32'h0, 100);
      chk("seq_addr", seen_addr, 32'(i));
    end
    chk("w0_valid", {31'd0, bus_if.inst_valid_o}, 32'd1);
    chk("w0_inst", bus_if.inst_o, 32'h0000_0013);
    chk("w0_pc", bus_if.pc_o, 32'h0);

    // Stall three cycles in HOLD, then consume.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 32'h0, 100);
      chk("stall_req", {31'd0, seen_req}, 32'd0);
      chk("stall_inst", bus_if.inst_o, 32'h0000_0013);
    end
    step(0, 1, 0, 0, 32'h0, 100);
    chk("consume_valid", {31'd0, bus_if.inst_valid_o}, 32'd0);

    // Two bytes from 0x4, then redirect while the third is acked.
    step(0, 1, 0, 0, 32'h0, 100);
    chk("next_addr", seen_addr, 32'h4);
    step(0, 1, 0, 0, 32'h0, 100);
    step(0, 1, 0, 1, 32'h100, 100);
    step(0, 1, 0, 0, 32'h0, 100);
    chk("jump_addr", seen_addr, 32'h100);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 100);
    chk("jw_inst", bus_if.inst_o, 32'hA7A6A5A4);
    chk("jw_pc", bus_if.pc_o, 32'h100);

    // Redirect while stalled in HOLD.
    step(0, 1, 1, 1, 32'h200, 100);
    chk("jstall_valid", {31'd0, bus_if.inst_valid_o}, 32'd0);
    step(0, 1, 0, 0, 32'h0, 100);
    chk("jstall_addr", seen_addr, 32'h200);

    // Freeze for five cycles after one byte.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 32'h0, 100);
      chk("frz_req", {31'd0, seen_req}, 32'd0);
    end
    step(0, 1, 0, 0, 32'h0, 100);
    chk("frz_resume", seen_addr, 32'h201);
    step(0, 1, 0, 0, 32'h0, 100);
    step(0, 1, 0, 0, 32'h0, 100);
    chk("frz_valid", {31'd0, bus_if.inst_valid_o}, 32'd1);

    // Redirect near the top of memory and wrap.
    step(0, 1, 0, 1, 32'hFFFF_FFFC, 100);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 32'h0, 100);
      chk("wrap_addr", seen_addr, 32'hFFFF_FFFC + 32'(i));
    end
    chk("wrap_pc", bus_if.pc_o, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 32'h0, 100);
    step(0, 1, 0, 0, 32'h0, 100);
    chk("wrap_next", seen_addr, 32'h0);

    // Synchronous reset mid-fetch.
    step(1, 1, 0, 0, 32'h0, 100);
    chk("mrst_valid", {31'd0, bus_if.inst_valid_o}, 32'd0);
    step(0, 1, 0, 0, 32'h0, 100);
    chk("mrst_addr", seen_addr, 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ja;
      ja = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(7))) : $urandom;
      step(($urandom_range(199) == 0), ($urandom_range(99) < 85), ($urandom_range(99) < 40),
           ($urandom_range(99) < 5), ja, 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
